video_timing_ctrl: RTL and testbench
====================================

// Module: video_timing_ctrl
// PURPOSE
//  Configuration sequencer for the VGA timing generator. Holds host-writable shadow timing
//  registers (h/v display, front porch, pulse, back porch), validates a requested mode and
//  commits it to the active timing outputs only at a frame boundary, then restarts the generator.
//  Sits between the host/OSD register bus and the timing generator's 12-bit timing inputs.
// PARAMETERS
//  TIMEOUT_CYC  2_000_000  max cycles waiting for frame_end before a forced apply
//  DEF_PRESET   0          preset loaded into shadow and active at reset (0 = 640x480@60)
// PORTS
//  clk           in   1   pixel clock, single clock domain
//  reset         in   1   asynchronous, active-high reset
//  wr_en         in   1   shadow register write strobe
//  wr_addr       in   3   shadow index: 0 h_display,1 h_fp,2 h_pulse,3 h_bp,4 v_display,5 v_fp,6 v_pulse,7 v_bp
//  wr_data       in   12  shadow write data
//  rd_addr       in   3   shadow read index; rd_data is combinational from shadow
//  rd_data       out  12  shadow read data
//  preset_load   in   1   pulse: copy preset[preset_sel] into all 8 shadow regs
//  preset_sel    in   2   0 640x480@60, 1 800x600@60, 2 1024x768@60, 3 1280x1024@60
//  commit_req    in   1   pulse: request shadow -> active commit
//  frame_end     in   1   pulse from generator at h_count==h_total && v_count==v_total
//  busy          out  1   high in CHECK/WAIT_FRAME/APPLY
//  commit_done   out  1   1-cycle pulse when active regs updated
//  cfg_err       out  1   sticky: last commit rejected; cleared by next accepted commit_req
//  forced        out  1   sticky: last apply was timeout-forced; cleared on next apply
//  tg_restart    out  1   1-cycle pulse, same cycle as commit_done: generator resets counters
//  act_*         out  12  x8 active timing fields (h_display..v_bp), registered
// BEHAVIOUR
//  Reset: shadow = active = preset[DEF_PRESET]; state IDLE; busy, commit_done, tg_restart,
//   cfg_err, forced = 0; timeout counter = 0.
//  FSM IDLE -> CHECK on commit_req (ignored while busy, no queueing).
//   CHECK (1 cycle): valid iff every display and pulse >= 1, and h_sum = h_display+h_fp+h_pulse+h_bp
//    <= 4096, same for v_sum; sums computed 14-bit, no truncation. Invalid -> cfg_err=1, IDLE.
//    Valid -> cfg_err=0, snapshot shadow into pending regs, WAIT_FRAME, clear timeout counter.
//   WAIT_FRAME: on frame_end -> APPLY. Counter increments each cycle; at TIMEOUT_CYC-1 without
//    frame_end -> APPLY with forced=1.
//   APPLY (1 cycle): act_* <= pending; commit_done=tg_restart=1; forced cleared unless timeout
//    path; -> IDLE. Commit latency with frame_end already pending: req+1 CHECK, +2 WAIT, APPLY
//    the cycle after frame_end is sampled.
//  Shadow writes are legal in any state; pending snapshot taken in CHECK isolates them, so a
//   write during WAIT_FRAME/APPLY affects only the next commit. Write and CHECK same cycle:
//   snapshot holds pre-write value.
//  preset_load and wr_en same cycle: preset wins for all 8 regs. preset_load never commits.
//  frame_end in IDLE/CHECK is ignored. frame_end same cycle as timeout expiry: normal apply,
//   forced=0.
//  Reset mid-operation: abort, all regs back to reset values; no commit_done emitted.
// STRUCTURE
//  Package video_timing_pkg: typedef struct packed timing_t (8 x logic[11:0]), register index
//   localparams, PRESET table timing_t[4] (640x480 {640,16,96,48,480,10,2,33}; 800x600
//   {800,40,128,88,600,1,4,23}; 1024x768 {1024,24,136,160,768,3,6,29}; 1280x1024
//   {1280,48,112,248,1024,1,3,38}), FSM state enum.
//  Sub-module video_timing_check: combinational validator, timing_t in -> valid, h_sum, v_sum.
// TESTING
//  Reset release -> act_* = {640,16,96,48,480,10,2,33}, busy=0, cfg_err=0, rd_data(0)=640.
//  preset_load sel=1, commit_req, frame_end 50 cyc later -> commit_done+tg_restart same cycle
//   after frame_end, act_h_display=800, act_v_bp=23, busy 0 next cycle.
//  Write h_pulse=0, commit_req -> cfg_err=1 after CHECK, act_* unchanged, no commit_done; h_fp=4000
//   with h_display=640 -> rejected (sum>4096).
//  Valid commit, write h_display=1024 during WAIT_FRAME -> applied act_h_display is old
//   snapshot value; second commit applies 1024.
//  TIMEOUT_CYC=100, no frame_end -> apply at cycle 100 after WAIT entry, forced=1.
//  Reset asserted in WAIT_FRAME -> act_* default, busy=0, no commit_done; commit_req while busy
//   ignored.

Source files
------------

// File: rtl/video_timing_pkg.sv
// Shared types, register indices and mode presets for the video timing configuration block.
package video_timing_pkg;

    typedef struct packed {
        logic [11:0] h_display;
        logic [11:0] h_fp;
        logic [11:0] h_pulse;
        logic [11:0] h_bp;
        logic [11:0] v_display;
        logic [11:0] v_fp;
        logic [11:0] v_pulse;
        logic [11:0] v_bp;
    } timing_t;

    localparam logic [2:0] IdxHDisplay = 3'd0;
    localparam logic [2:0] IdxHFp      = 3'd1;
    localparam logic [2:0] IdxHPulse   = 3'd2;
    localparam logic [2:0] IdxHBp      = 3'd3;
    localparam logic [2:0] IdxVDisplay = 3'd4;
    localparam logic [2:0] IdxVFp      = 3'd5;
    localparam logic [2:0] IdxVPulse   = 3'd6;
    localparam logic [2:0] IdxVBp      = 3'd7;

    // Largest legal total (display + porches + pulse) per axis.
    localparam logic [13:0] MaxTotal = 14'd4096;

    localparam timing_t PRESET [4] = '{
        {12'd640,  12'd16, 12'd96,  12'd48,  12'd480,  12'd10, 12'd2, 12'd33},
        {12'd800,  12'd40, 12'd128, 12'd88,  12'd600,  12'd1,  12'd4, 12'd23},
        {12'd1024, 12'd24, 12'd136, 12'd160, 12'd768,  12'd3,  12'd6, 12'd29},
        {12'd1280, 12'd48, 12'd112, 12'd248, 12'd1024, 12'd1,  12'd3, 12'd38}
    };

    typedef enum logic [1:0] {
        StIdle,
        StCheck,
        StWaitFrame,
        StApply
    } vtc_state_e;

    function automatic logic [11:0] field_get(input timing_t t, input logic [2:0] idx);
        logic [11:0] val;
        case (idx)
            IdxHDisplay: val = t.h_display;
            IdxHFp:      val = t.h_fp;
            IdxHPulse:   val = t.h_pulse;
            IdxHBp:      val = t.h_bp;
            IdxVDisplay: val = t.v_display;
            IdxVFp:      val = t.v_fp;
            IdxVPulse:   val = t.v_pulse;
            default:     val = t.v_bp;
        endcase
        return val;
    endfunction

    function automatic timing_t field_set(input timing_t t, input logic [2:0] idx,
                                          input logic [11:0] val);
        timing_t r;
        r = t;
        case (idx)
            IdxHDisplay: r.h_display = val;
            IdxHFp:      r.h_fp      = val;
            IdxHPulse:   r.h_pulse   = val;
            IdxHBp:      r.h_bp      = val;
            IdxVDisplay: r.v_display = val;
            IdxVFp:      r.v_fp      = val;
            IdxVPulse:   r.v_pulse   = val;
            default:     r.v_bp      = val;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/video_timing_check.sv
// Combinational mode validator: non-zero display/pulse widths and per-axis totals within range.
module video_timing_check
    import video_timing_pkg::*;
(
    input  timing_t     cfg,
    output logic        valid,
    output logic [13:0] h_sum,
    output logic [13:0] v_sum
);

    always_comb begin
        // 14-bit sums cannot wrap: 4 * 4095 < 2**14.
        h_sum = 14'(cfg.h_display) + 14'(cfg.h_fp) + 14'(cfg.h_pulse) + 14'(cfg.h_bp);
        v_sum = 14'(cfg.v_display) + 14'(cfg.v_fp) + 14'(cfg.v_pulse) + 14'(cfg.v_bp);
        valid = (cfg.h_display != 12'd0) && (cfg.h_pulse != 12'd0) &&
                (cfg.v_display != 12'd0) && (cfg.v_pulse != 12'd0) &&
                (h_sum <= MaxTotal) && (v_sum <= MaxTotal);
    end

endmodule

// File: rtl/video_timing_ctrl.sv
// Shadow/active timing register sequencer: validates a requested mode and commits it to the
// timing generator at a frame boundary (or after a timeout), then restarts the generator.
module video_timing_ctrl
    import video_timing_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 2_000_000,
    parameter int unsigned DEF_PRESET  = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr_en,
    input  logic [2:0]  wr_addr,
    input  logic [11:0] wr_data,
    input  logic [2:0]  rd_addr,
    output logic [11:0] rd_data,
    input  logic        preset_load,
    input  logic [1:0]  preset_sel,
    input  logic        commit_req,
    input  logic        frame_end,
    output logic        busy,
    output logic        commit_done,
    output logic        cfg_err,
    output logic        forced,
    output logic        tg_restart,
    output logic [11:0] act_h_display,
    output logic [11:0] act_h_fp,
    output logic [11:0] act_h_pulse,
    output logic [11:0] act_h_bp,
    output logic [11:0] act_v_display,
    output logic [11:0] act_v_fp,
    output logic [11:0] act_v_pulse,
    output logic [11:0] act_v_bp
);

    localparam int unsigned     CntW      = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CntW-1:0] CntLast   = CntW'(TIMEOUT_CYC - 1);
    localparam timing_t         DefTiming = PRESET[DEF_PRESET[1:0]];

    timing_t         shadow_q, shadow_d;
    timing_t         pending_q;
    timing_t         active_q;
    vtc_state_e      state_q, state_d;
    logic [CntW-1:0] cnt_q;
    logic            cfg_err_q;
    logic            forced_q;
    logic            chk_valid;
    logic [13:0]     h_sum, v_sum;
    logic            timeout_hit;
    logic            unused_sums;

    video_timing_check u_check (
        .cfg   (shadow_q),
        .valid (chk_valid),
        .h_sum (h_sum),
        .v_sum (v_sum)
    );

    assign unused_sums = ^{h_sum, v_sum};

    // A preset load overrides a same-cycle register write for every field.
    always_comb begin
        shadow_d = shadow_q;
        if (preset_load) begin
            shadow_d = PRESET[preset_sel];
        end else if (wr_en) begin
            shadow_d = field_set(shadow_q, wr_addr, wr_data);
        end
    end

    always_comb begin
        state_d     = state_q;
        timeout_hit = 1'b0;
        case (state_q)
            StIdle: begin
                if (commit_req) state_d = StCheck;
            end
            StCheck: begin
                state_d = chk_valid ? StWaitFrame : StIdle;
            end
            StWaitFrame: begin
                if (frame_end) begin
                    state_d = StApply;
                end else if (cnt_q == CntLast) begin
                    state_d     = StApply;
                    timeout_hit = 1'b1;
                end
            end
            StApply: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            shadow_q  <= DefTiming;
            pending_q <= DefTiming;
            active_q  <= DefTiming;
            cnt_q     <= '0;
            cfg_err_q <= 1'b0;
            forced_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            shadow_q <= shadow_d;
            case (state_q)
                StIdle: begin
                    if (commit_req) cfg_err_q <= 1'b0;
                end
                StCheck: begin
                    cnt_q <= '0;
                    // Snapshot uses the pre-write shadow so later writes only affect the next commit.
                    if (chk_valid) pending_q <= shadow_q;
                    else           cfg_err_q <= 1'b1;
                end
                StWaitFrame: begin
                    cnt_q <= cnt_q + CntW'(1);
                    if (state_d == StApply) forced_q <= timeout_hit;
                end
                StApply: begin
                    active_q <= pending_q;
                end
                default: ;
            endcase
        end
    end

    assign rd_data     = field_get(shadow_q, rd_addr);
    assign busy        = (state_q != StIdle);
    assign commit_done = (state_q == StApply);
    assign tg_restart  = (state_q == StApply);
    assign cfg_err     = cfg_err_q;
    assign forced      = forced_q;

    assign act_h_display = active_q.h_display;
    assign act_h_fp      = active_q.h_fp;
    assign act_h_pulse   = active_q.h_pulse;
    assign act_h_bp      = active_q.h_bp;
    assign act_v_display = active_q.v_display;
    assign act_v_fp      = active_q.v_fp;
    assign act_v_pulse   = active_q.v_pulse;
    assign act_v_bp      = active_q.v_bp;

endmodule

// File: tb/tb_video_timing_ctrl.sv
// Directed bench for video_timing_ctrl with a short commit timeout.
module tb_video_timing_ctrl;

    logic        clk;
    logic        reset;
    logic        wr_en;
    logic [2:0]  wr_addr;
    logic [11:0] wr_data;
    logic [2:0]  rd_addr;
    logic [11:0] rd_data;
    logic        preset_load;
    logic [1:0]  preset_sel;
    logic        commit_req;
    logic        frame_end;
    logic        busy;
    logic        commit_done;
    logic        cfg_err;
    logic        forced;
    logic        tg_restart;
    logic [11:0] act_h_display, act_h_fp, act_h_pulse, act_h_bp;
    logic [11:0] act_v_display, act_v_fp, act_v_pulse, act_v_bp;

    int n_cmp    = 0;
    int n_err    = 0;
    int done_cnt = 0;

    video_timing_ctrl #(
        .TIMEOUT_CYC (100),
        .DEF_PRESET  (0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .wr_data       (wr_data),
        .rd_addr       (rd_addr),
        .rd_data       (rd_data),
        .preset_load   (preset_load),
        .preset_sel    (preset_sel),
        .commit_req    (commit_req),
        .frame_end     (frame_end),
        .busy          (busy),
        .commit_done   (commit_done),
        .cfg_err       (cfg_err),
        .forced        (forced),
        .tg_restart    (tg_restart),
        .act_h_display (act_h_display),
        .act_h_fp      (act_h_fp),
        .act_h_pulse   (act_h_pulse),
        .act_h_bp      (act_h_bp),
        .act_v_display (act_v_display),
        .act_v_fp      (act_v_fp),
        .act_v_pulse   (act_v_pulse),
        .act_v_bp      (act_v_bp)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) if (commit_done === 1'b1) done_cnt++;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shadow_write(input logic [2:0] addr, input logic [11:0] data);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        tick();
        wr_en   = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [2:0] addr, input logic [11:0] exp);
        rd_addr = addr;
        #1;
        check_eq(tag, 32'(rd_data), 32'(exp));
    endtask

    // Request a commit and return one cycle later, with the FSM in WAIT_FRAME (or IDLE if rejected).
    task automatic request_commit();
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        tick();
    endtask

    task automatic frame_pulse_apply(input string tag);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_eq({tag, "_done"}, 32'(commit_done), 32'd1);
        tick();
        check_eq({tag, "_idle"}, 32'(busy), 32'd0);
    endtask

    logic [11:0] def_tbl [8];
    int          d0;
    int          n;

    initial begin
        def_tbl = '{12'd640, 12'd16, 12'd96, 12'd48, 12'd480, 12'd10, 12'd2, 12'd33};
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; rd_addr = '0;
        preset_load = 1'b0; preset_sel = '0; commit_req = 1'b0; frame_end = 1'b0;
        tick();
        tick();

        // Reset state
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_cfg_err", 32'(cfg_err), 32'd0);
        check_eq("rst_forced", 32'(forced), 32'd0);
        check_eq("rst_done", 32'(commit_done), 32'd0);
        check_eq("rst_act_hd", 32'(act_h_display), 32'd640);
        check_eq("rst_act_hp", 32'(act_h_pulse), 32'd96);
        check_eq("rst_act_vd", 32'(act_v_display), 32'd480);
        check_eq("rst_act_vbp", 32'(act_v_bp), 32'd33);
        for (int i = 0; i < 8; i++) rd_check($sformatf("rst_shadow%0d", i), 3'(i), def_tbl[i]);
        reset = 1'b0;
        tick();

        // Preset load beats a same-cycle write; commit with frame_end ~50 cycles later
        preset_load = 1'b1; preset_sel = 2'd1;
        wr_en = 1'b1; wr_addr = 3'd0; wr_data = 12'd123;
        tick();
        preset_load = 1'b0; wr_en = 1'b0;
        rd_check("preset_wins", 3'd0, 12'd800);
        check_eq("preset_no_commit", 32'(act_h_display), 32'd640);
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        check_eq("check_busy", 32'(busy), 32'd1);
        tick();
        repeat (48) tick();
        check_eq("wait_no_done", 32'(commit_done), 32'd0);
        check_eq("wait_busy", 32'(busy), 32'd1);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_eq("p1_done", 32'(commit_done), 32'd1);
        check_eq("p1_restart", 32'(tg_restart), 32'd1);
        tick();
        check_eq("p1_busy_after", 32'(busy), 32'd0);
        check_eq("p1_done_after", 32'(commit_done), 32'd0);
        check_eq("p1_act_hd", 32'(act_h_display), 32'd800);
        check_eq("p1_act_vbp", 32'(act_v_bp), 32'd23);
        check_eq("p1_forced", 32'(forced), 32'd0);

        // Rejections: zero pulse, h total over range, total one past the limit
        shadow_write(3'd2, 12'd0);
        d0 = done_cnt;
        request_commit();
        check_eq("rej_pulse_err", 32'(cfg_err), 32'd1);
        check_eq("rej_pulse_busy", 32'(busy), 32'd0);
        tick();
        check_eq("rej_pulse_nodone", 32'(done_cnt), 32'(d0));
        check_eq("rej_pulse_act_hp", 32'(act_h_pulse), 32'd128);
        shadow_write(3'd2, 12'd96);
        shadow_write(3'd0, 12'd640);
        shadow_write(3'd1, 12'd4000);
        request_commit();
        check_eq("rej_sum_err", 32'(cfg_err), 32'd1);
        check_eq("rej_sum_busy", 32'(busy), 32'd0);
        shadow_write(3'd0, 12'd1000);
        shadow_write(3'd1, 12'd2913);
        request_commit();
        check_eq("rej_4097_err", 32'(cfg_err), 32'd1);
        check_eq("rej_act_hd", 32'(act_h_display), 32'd800);

        // Exactly 4096 is accepted and clears cfg_err
        shadow_write(3'd1, 12'd2912);
        request_commit();
        check_eq("acc_4096_err", 32'(cfg_err), 32'd0);
        check_eq("acc_4096_busy", 32'(busy), 32'd1);
        frame_pulse_apply("acc_4096");
        check_eq("acc_act_hd", 32'(act_h_display), 32'd1000);
        check_eq("acc_act_hfp", 32'(act_h_fp), 32'd2912);

        // frame_end while idle is ignored
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_eq("idle_fe_busy", 32'(busy), 32'd0);
        check_eq("idle_fe_done", 32'(commit_done), 32'd0);

        // Writes in CHECK and WAIT_FRAME do not reach this commit; commit_req while busy ignored
        preset_load = 1'b1; preset_sel = 2'd0;
        tick();
        preset_load = 1'b0;
        commit_req = 1'b1;
        tick();
        commit_req = 1'b0;
        wr_en = 1'b1; wr_addr = 3'd1; wr_data = 12'd20;
        tick();
        wr_addr = 3'd0; wr_data = 12'd1024; commit_req = 1'b1;
        tick();
        wr_en = 1'b0; commit_req = 1'b0;
        d0 = done_cnt;
        frame_pulse_apply("snap");
        check_eq("snap_act_hd", 32'(act_h_display), 32'd640);
        check_eq("snap_act_hfp", 32'(act_h_fp), 32'd16);
        tick();
        check_eq("no_queue_busy", 32'(busy), 32'd0);
        check_eq("no_queue_cnt", 32'(done_cnt), 32'(d0 + 1));
        rd_check("snap_shadow_hd", 3'd0, 12'd1024);
        rd_check("snap_shadow_hfp", 3'd1, 12'd20);
        request_commit();
        frame_pulse_apply("second");
        check_eq("second_act_hd", 32'(act_h_display), 32'd1024);
        check_eq("second_act_hfp", 32'(act_h_fp), 32'd20);

        // Timeout: apply lands 100 cycles after WAIT_FRAME entry
        request_commit();
        n = 0;
        while (commit_done !== 1'b1 && n < 150) begin
            tick();
            n++;
        end
        check_eq("to_seen", 32'(commit_done), 32'd1);
        check_eq("to_latency", 32'(n), 32'd100);
        check_eq("to_forced", 32'(forced), 32'd1);
        tick();
        check_eq("to_forced_sticky", 32'(forced), 32'd1);
        check_eq("to_idle", 32'(busy), 32'd0);

        // frame_end coincident with timeout expiry is a normal apply
        request_commit();
        repeat (99) tick();
        check_eq("coinc_still_wait", 32'(commit_done), 32'd0);
        frame_end = 1'b1;
        tick();
        frame_end = 1'b0;
        check_eq("coinc_done", 32'(commit_done), 32'd1);
        check_eq("coinc_forced", 32'(forced), 32'd0);
        tick();

        // Reset in WAIT_FRAME aborts with no commit_done
        preset_load = 1'b1; preset_sel = 2'd3;
        tick();
        preset_load = 1'b0;
        request_commit();
        repeat (5) tick();
        check_eq("abort_wait_busy", 32'(busy), 32'd1);
        d0 = done_cnt;
        reset = 1'b1;
        #1;
        check_eq("abort_busy", 32'(busy), 32'd0);
        check_eq("abort_done", 32'(commit_done), 32'd0);
        check_eq("abort_act_hd", 32'(act_h_display), 32'd640);
        check_eq("abort_act_vbp", 32'(act_v_bp), 32'd33);
        rd_check("abort_shadow_hd", 3'd0, 12'd640);
        tick();
        tick();
        reset = 1'b0;
        repeat (3) tick();
        check_eq("abort_no_done", 32'(done_cnt), 32'(d0));
        check_eq("abort_idle", 32'(busy), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
